// File: rtl/input_port_buffer_pkg.sv
// Shared flit format, flit id codes and FSM encoding for the router input port.
package input_port_buffer_pkg;
  localparam int FLIT_W = 32;
  localparam int LEN_W  = 12;
  localparam int ID_W   = 3;
  localparam int ID_LSB = 29;
  localparam int ID_MSB = 31;

  localparam logic [ID_W-1:0] ID_HEAD = 3'b001;
  localparam logic [ID_W-1:0] ID_BODY = 3'b010;
  localparam logic [ID_W-1:0] ID_TAIL = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  function automatic logic [ID_W-1:0] id_of(input logic [FLIT_W-1:0] flit);
    return flit[ID_MSB:ID_LSB];
  endfunction
endpackage

// File: rtl/input_port_buffer_flit_fifo.sv
// Synchronous flit FIFO with a combinational head so the port FSM can inspect it.
module flit_fifo
  import input_port_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [FLIT_W-1:0]          din,
  output logic                       full,
  output logic                       empty,
  output logic [FLIT_W-1:0]          head,
  output logic [$clog2(DEPTH):0]     count
);
  localparam int AW = $clog2(DEPTH);

  logic [FLIT_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr_reg;
  logic [AW-1:0]     rd_ptr_reg;
  logic [AW:0]       count_reg;

  // Storage carries no reset; count and pointers alone decide what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr_reg] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
      if (pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
      case ({push, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign full  = (count_reg == (AW+1)'(DEPTH));
  assign empty = (count_reg == '0);
  assign head  = mem[rd_ptr_reg];
  assign count = count_reg;
endmodule

// File: rtl/input_port_buffer.sv
// Router input port: buffers flits, requests the arbiter per packet and
// forwards granted flits to the crossbar one cycle after they are popped.
module input_port_buffer
  import input_port_buffer_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              grant,
  output logic              req,
  output logic [ID_W-1:0]   flit_id,
  output logic [LEN_W-1:0]  length,
  output logic [FLIT_W-1:0] flit_out,
  output logic              out_valid,
  output logic              drop
);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  state_t            state_reg;
  logic              full;
  logic              empty;
  logic [FLIT_W-1:0] head;
  logic [CNT_W-1:0]  count;
  logic              push;
  logic              pop;
  logic              fwd;
  logic              discard;
  logic [ID_W-1:0]   head_id;
  logic              head_is_hdr;

  // Full FIFO refuses input even when a pop happens in the same cycle.
  assign in_ready = (count < CNT_W'(DEPTH));
  assign push     = in_valid & ~full;

  flit_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .din   (flit_in),
    .full  (full),
    .empty (empty),
    .head  (head),
    .count (count)
  );

  assign head_id     = empty ? '0 : id_of(head);
  assign head_is_hdr = (head_id == ID_HEAD);
  assign flit_id     = head_id;
  assign length      = empty ? '0 : head[LEN_W-1:0];

  // A header waiting in IDLE already requests, so the arbiter sees it one cycle earlier.
  assign req = (state_reg != ST_IDLE) || head_is_hdr;

  always_comb begin
    fwd     = 1'b0;
    discard = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty) begin
          if (!head_is_hdr) discard = 1'b1;
          else if (grant)   fwd     = 1'b1;
        end
      end
      ST_REQ, ST_XFER: fwd = grant & ~empty;
      default: ;
    endcase
    pop = fwd | discard;
  end

  // Stray flits are discarded, not forwarded; only fwd pops reach the crossbar.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= ST_IDLE;
      out_valid <= 1'b0;
      flit_out  <= '0;
      drop      <= 1'b0;
    end else begin
      out_valid <= fwd;
      drop      <= discard;
      if (fwd) flit_out <= head;
      case (state_reg)
        ST_IDLE: begin
          if (head_is_hdr) state_reg <= grant ? ST_XFER : ST_REQ;
        end
        ST_REQ: begin
          if (fwd) state_reg <= ST_XFER;
        end
        ST_XFER: begin
          if (fwd && head_id == ID_TAIL) state_reg <= ST_IDLE;
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: per-cycle stimulus with hand-derived expectations.
module tb_input_port_buffer;
  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] flit_in;
  logic        in_valid;
  logic        in_ready;
  logic        grant;
  logic        req;
  logic [2:0]  flit_id;
  logic [11:0] length;
  logic [31:0] flit_out;
  logic        out_valid;
  logic        drop;

  int checks   = 0;
  int failures = 0;

  input_port_buffer #(.DEPTH(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .flit_in   (flit_in),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .grant     (grant),
    .req       (req),
    .flit_id   (flit_id),
    .length    (length),
    .flit_out  (flit_out),
    .out_valid (out_valid),
    .drop      (drop)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mk(input logic [2:0] id, input logic [16:0] tag,
                                     input logic [11:0] len);
    return {id, tag, len};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end else begin
      $display("ok   %s = %h", tag, got);
    end
  endtask

  // One cycle: inputs applied 1ns after the edge, outputs sampled 2ns later.
  task automatic tick(input logic v, input logic [31:0] f, input logic g);
    @(posedge clk);
    #1;
    in_valid = v;
    flit_in  = f;
    grant    = g;
    #2;
  endtask

  // rst is held for one edge while the previous cycle's inputs stay applied.
  task automatic do_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst      = 1'b0;
    in_valid = 1'b0;
    flit_in  = '0;
    grant    = 1'b0;
    #2;
  endtask

  logic [31:0] h5, b1, b2, b3, tl, h7, h3, bs;

  initial begin
    h5 = mk(3'b001, 17'h0, 12'd5);
    h7 = mk(3'b001, 17'h0, 12'd7);
    h3 = mk(3'b001, 17'h0, 12'd3);
    b1 = mk(3'b010, 17'h1, 12'h0ab);
    b2 = mk(3'b010, 17'h2, 12'h0cd);
    b3 = mk(3'b010, 17'h3, 12'h0ef);
    tl = mk(3'b100, 17'h4, 12'h123);
    bs = mk(3'b010, 17'h5, 12'h456);

    rst = 1'b1; in_valid = 1'b0; flit_in = '0; grant = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    #2;
    check("rst_req", 32'(req), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd1);
    check("rst_flit_id", 32'(flit_id), 32'd0);
    check("rst_length", 32'(length), 32'd0);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_flit_out", flit_out, 32'd0);
    check("rst_drop", 32'(drop), 32'd0);

    // Three-flit packet, grant from the cycle after req rises.
    tick(1, h5, 0); check("p1_c0_req", 32'(req), 32'd0);
    tick(1, b1, 0); check("p1_c1_req", 32'(req), 32'd1);
                    check("p1_c1_id", 32'(flit_id), 32'd1);
                    check("p1_c1_len", 32'(length), 32'd5);
    tick(1, tl, 1); check("p1_c2_ov", 32'(out_valid), 32'd0);
    tick(0, 0, 1);  check("p1_c3_ov", 32'(out_valid), 32'd1);
                    check("p1_c3_fo", flit_out, h5);
    tick(0, 0, 1);  check("p1_c4_fo", flit_out, b1);
                    check("p1_c4_req", 32'(req), 32'd1);
    tick(0, 0, 0);  check("p1_c5_ov", 32'(out_valid), 32'd1);
                    check("p1_c5_fo", flit_out, tl);
                    check("p1_c5_req", 32'(req), 32'd0);
    tick(0, 0, 0);  check("p1_c6_ov", 32'(out_valid), 32'd0);
                    check("p1_c6_hold", flit_out, tl);

    // Five back-to-back pushes into a 4-deep FIFO with no grant.
    do_reset();
    tick(1, h7, 0); check("p2_c0_rdy", 32'(in_ready), 32'd1);
    tick(1, b1, 0); check("p2_c1_rdy", 32'(in_ready), 32'd1);
    tick(1, b2, 0);
    tick(1, b3, 0); check("p2_c3_rdy", 32'(in_ready), 32'd1);
    tick(1, tl, 0); check("p2_c4_rdy", 32'(in_ready), 32'd0);
    tick(0, 0, 0);  check("p2_count", 32'(dut.u_fifo.count), 32'd4);
    tick(0, 0, 1);
    tick(0, 0, 1);  check("p2_fo_h", flit_out, h7);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);  check("p2_fo_b3", flit_out, b3);
    tick(0, 0, 1);  check("p2_no_5th", 32'(out_valid), 32'd0);

    // Grant withdrawn for three cycles mid-packet.
    do_reset();
    tick(1, h5, 0);
    tick(1, b1, 0);
    tick(1, b2, 1);
    tick(1, tl, 1); check("p3_c3_fo", flit_out, h5);
    tick(0, 0, 0);  check("p3_c4_fo", flit_out, b1);
    tick(0, 0, 0);  check("p3_c5_ov", 32'(out_valid), 32'd0);
                    check("p3_c5_req", 32'(req), 32'd1);
    tick(0, 0, 0);  check("p3_c6_ov", 32'(out_valid), 32'd0);
    tick(0, 0, 1);  check("p3_c7_ov", 32'(out_valid), 32'd0);
                    check("p3_c7_req", 32'(req), 32'd1);
    tick(0, 0, 1);  check("p3_c8_fo", flit_out, b2);
                    check("p3_c8_ov", 32'(out_valid), 32'd1);
    tick(0, 0, 0);  check("p3_c9_fo", flit_out, tl);
                    check("p3_c9_req", 32'(req), 32'd0);

    // Stray body in IDLE followed by a good packet.
    do_reset();
    tick(1, bs, 0);
    tick(1, h3, 0); check("p4_c1_req", 32'(req), 32'd0);
                    check("p4_c1_drop", 32'(drop), 32'd0);
    tick(1, tl, 0); check("p4_c2_drop", 32'(drop), 32'd1);
                    check("p4_c2_req", 32'(req), 32'd1);
                    check("p4_c2_len", 32'(length), 32'd3);
    tick(0, 0, 1);  check("p4_c3_drop", 32'(drop), 32'd0);
    tick(0, 0, 1);  check("p4_c4_fo", flit_out, h3);
    tick(0, 0, 0);  check("p4_c5_fo", flit_out, tl);
                    check("p4_c5_req", 32'(req), 32'd0);

    // Reset in XFER with two flits buffered, grant and in_valid still high.
    do_reset();
    tick(1, h5, 0);
    tick(1, b1, 0);
    tick(1, b2, 1);
    tick(1, b3, 1); check("p5_pre_req", 32'(req), 32'd1);
    do_reset();
    check("p5_req", 32'(req), 32'd0);
    check("p5_ov", 32'(out_valid), 32'd0);
    check("p5_rdy", 32'(in_ready), 32'd1);
    check("p5_id", 32'(flit_id), 32'd0);
    check("p5_count", 32'(dut.u_fifo.count), 32'd0);

    // Full FIFO with a same-cycle pop must not accept the offered flit.
    do_reset();
    tick(1, h5, 0);
    tick(1, b1, 0);
    tick(1, b2, 0);
    tick(1, b3, 0);
    tick(1, tl, 1); check("p6_rdy_full", 32'(in_ready), 32'd0);
    tick(0, 0, 1);  check("p6_count", 32'(dut.u_fifo.count), 32'd3);
                    check("p6_fo_h", flit_out, h5);
    tick(0, 0, 1);
    tick(0, 0, 1);
    tick(0, 0, 1);  check("p6_fo_b3", flit_out, b3);
    tick(0, 0, 0);  check("p6_empty", 32'(dut.u_fifo.count), 32'd0);
                    check("p6_ov", 32'(out_valid), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
